// File: rtl/riscv_defines_pkg.sv
// rtl/riscv_defines_pkg.sv - load/store size codes, FSM states and lane helpers
package riscv_defines;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Size/alignment rejection only; the address window is checked by the top.
  function automatic logic access_fault(input logic we, input logic [2:0] size,
                                        input logic [1:0] lane);
    logic f;
    case (size)
      LDST_B:  f = 1'b0;
      LDST_BU: f = we;
      LDST_H:  f = lane[0];
      LDST_HU: f = we | lane[0];
      LDST_W:  f = |lane;
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      LDST_B, LDST_BU: be = 4'b0001 << lane;
      LDST_H, LDST_HU: be = lane[1] ? 4'b1100 : 4'b0011;
      default:         be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      LDST_B, LDST_BU: d = {4{wd[7:0]}};
      LDST_H, LDST_HU: d = {2{wd[15:0]}};
      default:         d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] size, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] d;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      LDST_B:  d = {{24{b[7]}}, b};
      LDST_BU: d = {24'h0, b};
      LDST_H:  d = {{16{h[15]}}, h};
      LDST_HU: d = {16'h0, h};
      default: d = word;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - DEPTH_WORDS x 32 array, byte-enabled sync write, sync read
module data_mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < 4; i++) begin
          if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/riscv_data_mem_responder.sv
// rtl/riscv_data_mem_responder.sv - data-memory responder with fixed access latency and fault checks
module riscv_data_mem_responder
  import riscv_defines::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [2:0]  mem_size_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] WD_i,
  output logic [31:0] RD_o,
  output logic        stall_o,
  output logic        fault_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0]   WIN_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [CW-1:0] CNT_INIT  = CW'(LATENCY - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [2:0]    size_q, size_d;
  logic [1:0]    lane_q, lane_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          fault_q, fault_d;

  logic [31:0] off;
  logic        in_window;
  logic        req_fault;
  logic        arr_en;
  logic [31:0] arr_rdata;

  assign off       = data_addr_i - BASE_ADDR;
  assign in_window = (data_addr_i >= BASE_ADDR) && ({1'b0, off} < WIN_BYTES);
  assign req_fault = access_fault(mem_we_i, mem_size_i, off[1:0]) | ~in_window;
  assign arr_en    = (state_q == ST_BUSY) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    lane_d  = lane_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    fault_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_req_i) begin
          we_d    = mem_we_i;
          size_d  = mem_size_i;
          lane_d  = off[1:0];
          idx_d   = off[AW+1:2];
          wdata_d = WD_i;
          cnt_d   = CNT_INIT;
          if (req_fault) begin
            fault_d = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else             state_d = ST_RESP;
      end
      // A request still asserted here belongs to the instruction just answered.
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      lane_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      fault_q <= fault_d;
    end
  end

  data_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk_i  (clk_i),
    .en_i   (arr_en),
    .we_i   (we_q),
    .be_i   (byte_en(size_q, lane_q)),
    .addr_i (idx_q),
    .wdata_i(store_data(size_q, wdata_q)),
    .rdata_o(arr_rdata)
  );

  assign stall_o = ~rst_i & (((state_q == ST_IDLE) & mem_req_i) | (state_q == ST_BUSY));
  assign fault_o = fault_q;
  assign RD_o    = ((state_q == ST_RESP) && !fault_q && !we_q)
                   ? load_extend(size_q, lane_q, arr_rdata) : 32'h0;

endmodule

// File: tb/tb_riscv_data_mem_responder.sv
// tb/tb_riscv_data_mem_responder.sv - directed vector bench for riscv_data_mem_responder
module tb_riscv_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        stall;
  logic        fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_data_mem_responder #(
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (32'h0000_0000),
    .LATENCY    (2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mem_req_i  (req),
    .mem_we_i   (we),
    .mem_size_i (size),
    .data_addr_i(addr),
    .WD_i       (wd),
    .RD_o       (rd),
    .stall_o    (stall),
    .fault_o    (fault)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        fault;
    int          stalls;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic w, input logic [2:0] s, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] r, input logic f, input int st);
    vec_t v;
    v.name = n; v.we = w; v.size = s; v.addr = a; v.wd = d; v.rd = r; v.fault = f; v.stalls = st;
    vecs.push_back(v);
  endtask

  // Issues one access and holds it until the first non-stalled cycle (the RESP cycle).
  task automatic access(input logic w, input logic [2:0] s, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] r, output logic f,
                        output int st, output logic timeout);
    @(posedge clk); #1;
    req = 1'b1; we = w; size = s; addr = a; wd = d;
    st = 0; timeout = 1'b1; r = '0; f = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!stall) begin
        r = rd; f = fault; timeout = 1'b0;
        break;
      end
      st++;
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  logic [31:0] r_act;
  logic        f_act;
  int          st_act;
  logic        to;

  initial begin
    rst = 1'b1; req = 1'b1; we = 1'b0; size = 3'b010; addr = 32'h10; wd = '0;

    add("sw_10",    1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 3);
    add("lw_10",    1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 3);
    add("lb_13",    1'b0, 3'b000, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0, 3);
    add("lbu_13",   1'b0, 3'b100, 32'h13,   32'h0,        32'h000000DE, 1'b0, 3);
    add("lh_12",    1'b0, 3'b001, 32'h12,   32'h0,        32'hFFFFDEAD, 1'b0, 3);
    add("lhu_10",   1'b0, 3'b101, 32'h10,   32'h0,        32'h0000BEEF, 1'b0, 3);
    add("sb_11",    1'b1, 3'b000, 32'h11,   32'h12345655, 32'h0,        1'b0, 3);
    add("lw_10b",   1'b0, 3'b010, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0, 3);
    add("lb_11pos", 1'b0, 3'b000, 32'h11,   32'h0,        32'h00000055, 1'b0, 3);
    add("lw_mis",   1'b0, 3'b010, 32'h12,   32'h0,        32'h0,        1'b1, 1);
    add("sh_mis",   1'b1, 3'b001, 32'h11,   32'hFFFFFFFF, 32'h0,        1'b1, 1);
    add("lw_10c",   1'b0, 3'b010, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0, 3);
    add("lw_oow",   1'b0, 3'b010, 32'h1000, 32'h0,        32'h0,        1'b1, 1);
    add("size_011", 1'b0, 3'b011, 32'h10,   32'h0,        32'h0,        1'b1, 1);
    add("st_bu",    1'b1, 3'b100, 32'h10,   32'h0,        32'h0,        1'b1, 1);
    add("sh_16",    1'b1, 3'b001, 32'h16,   32'hCAFE8001, 32'h0,        1'b0, 3);
    add("lh_16",    1'b0, 3'b001, 32'h16,   32'h0,        32'hFFFF8001, 1'b0, 3);
    add("lhu_16",   1'b0, 3'b101, 32'h16,   32'h0,        32'h00008001, 1'b0, 3);
    add("lb_17",    1'b0, 3'b000, 32'h17,   32'h0,        32'hFFFFFF80, 1'b0, 3);
    add("lbu_16",   1'b0, 3'b100, 32'h16,   32'h0,        32'h00000001, 1'b0, 3);
    add("sw_last",  1'b1, 3'b010, 32'hFFC,  32'h01020304, 32'h0,        1'b0, 3);
    add("lw_last",  1'b0, 3'b010, 32'hFFC,  32'h0,        32'h01020304, 1'b0, 3);
    add("lw_10d",   1'b0, 3'b010, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0, 3);

    // Reset holds outputs low even with a request pending.
    repeat (2) @(negedge clk);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_rd",    rd,             32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      access(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wd, r_act, f_act, st_act, to);
      chk({vecs[i].name, "_timeout"}, {31'h0, to},    32'h0);
      chk({vecs[i].name, "_rd"},      r_act,          vecs[i].rd);
      chk({vecs[i].name, "_fault"},   {31'h0, f_act}, {31'h0, vecs[i].fault});
      chk({vecs[i].name, "_stalls"},  st_act,         vecs[i].stalls);
    end

    // Outside RESP the response lines stay at zero.
    @(negedge clk);
    chk("idle_rd",    rd,             32'h0);
    chk("idle_fault", {31'h0, fault}, 32'h0);
    chk("idle_stall", {31'h0, stall}, 32'h0);

    // Store aborted by reset while BUSY must not reach the array.
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; size = 3'b010; addr = 32'h10; wd = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_stall", {31'h0, stall}, 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    chk("midrst_rd",    rd,             32'h0);
    chk("midrst_fault", {31'h0, fault}, 32'h0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", {31'h0, stall}, 32'h0);
    access(1'b0, 3'b010, 32'h10, 32'h0, r_act, f_act, st_act, to);
    chk("post_rst_timeout", {31'h0, to},    32'h0);
    chk("post_rst_lw",      r_act,          32'hDEAD55EF);
    chk("post_rst_fault",   {31'h0, f_act}, 32'h0);
    chk("post_rst_stalls",  st_act,         3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
